// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between instruction fetch (I) and data access (D) with D priority and bounded I starvation
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_data_ok,
  output logic [63:0] d_data,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_resp_valid,
  input  logic [63:0] m_resp_data,
  output logic        grant_d
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state, state_n;
  logic [3:0] starve_cnt;
  logic grant, pick_d;
  always_comb begin
    grant = state == IDLE && (i_valid || d_valid);
    pick_d = d_valid && !(i_valid && starve_cnt == LIMIT);
    state_n = state == IDLE  ? (grant ? ISSUE : IDLE) :
              state == ISSUE ? (m_ready ? WAIT : ISSUE) :
              state == WAIT  ? (m_resp_valid ? IDLE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m_addr <= '0;
      m_size <= '0;
      m_strobe <= '0;
      m_wdata <= '0;
      grant_d <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        m_addr <= pick_d ? d_addr : i_addr;
        m_size <= pick_d ? d_size : 3'd2;
        m_strobe <= pick_d ? d_strobe : 8'd0;
        m_wdata <= pick_d ? d_wdata : 64'd0;
        grant_d <= pick_d;
        starve_cnt <= (pick_d && i_valid) ? (starve_cnt == LIMIT ? LIMIT : starve_cnt + 4'd1) : 4'd0;
      end
    end
  end
  assign m_valid = state == ISSUE;
  assign i_data_ok = state == WAIT && m_resp_valid && !grant_d;
  assign d_data_ok = state == WAIT && m_resp_valid && grant_d;
  assign i_data = m_addr[2] ? m_resp_data[63:32] : m_resp_data[31:0];
  assign d_data = m_resp_data;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with a response scoreboard for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clk = 0, reset = 1;
  logic i_valid = 0, d_valid = 0, m_ready = 0, m_resp_valid = 0;
  logic [63:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_resp_data = 0;
  logic [2:0] d_size = 0;
  logic [7:0] d_strobe = 0;
  logic i_data_ok, d_data_ok, m_valid, grant_d;
  logic [31:0] i_data;
  logic [63:0] d_data, m_addr, m_wdata;
  logic [2:0] m_size;
  logic [7:0] m_strobe;
  int checks = 0, passed = 0;
  typedef struct packed {logic d; logic [63:0] data;} exp_t;
  exp_t q[$];
  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_resp_valid(m_resp_valid),
    .m_resp_data(m_resp_data), .grant_d(grant_d)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  // Monitor: every data_ok pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (i_data_ok || d_data_ok) begin
      checks++;
      if (i_data_ok && d_data_ok)
        $display("FAIL both_data_ok: got i=1 d=1 want one-hot");
      else if (q.size() == 0)
        $display("FAIL unexpected_data_ok: got i=%0b d=%0b want none", i_data_ok, d_data_ok);
      else begin
        exp_t e;
        logic [63:0] act;
        e = q.pop_front();
        act = d_data_ok ? d_data : {32'd0, i_data};
        if (d_data_ok == e.d && act === e.data) passed++;
        else $display("FAIL resp: got d=%0b data=%h want d=%0b data=%h", d_data_ok, act, e.d, e.data);
      end
    end
  end
  // Entered in the IDLE cycle where the request is presented; returns in the following IDLE cycle.
  task automatic txn(input logic ed, input logic [63:0] ea, input logic [2:0] es,
                     input logic [7:0] est, input logic [63:0] ew, input logic [63:0] rd,
                     input logic [63:0] er, input int bp, input int lat, input bit drop);
    step;
    for (int i = 0; i < bp; i++) begin
      m_ready = 0;
      m_resp_valid = (i == 1);
      m_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_addr", m_addr, ea);
      step;
    end
    m_resp_valid = 0;
    m_ready = 1;
    @(negedge clk);
    chk("m_valid", m_valid, 1);
    chk("m_addr", m_addr, ea);
    chk("m_size", m_size, es);
    chk("m_strobe", m_strobe, est);
    chk("m_wdata", m_wdata, ew);
    chk("grant_d", grant_d, ed);
    step;
    m_ready = 0;
    if (drop) begin
      i_valid = 0;
      d_valid = 0;
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wait_m_valid", m_valid, 0);
      step;
    end
    m_resp_valid = 1;
    m_resp_data = rd;
    q.push_back({ed, er});
    @(negedge clk);
    chk("owner_ok", ed ? d_data_ok : i_data_ok, 1);
    chk("other_ok", ed ? i_data_ok : d_data_ok, 0);
    step;
    m_resp_valid = 0;
  endtask
  initial begin
    step;
    step;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_size", m_size, 0);
    chk("rst_grant_d", grant_d, 0);
    chk("rst_data_ok", {i_data_ok, d_data_ok}, 0);
    step;
    reset = 0;
    // single fetch from the upper word
    i_valid = 1;
    i_addr = 64'h8000_0004;
    @(negedge clk);
    chk("idle_m_valid", m_valid, 0);
    txn(0, 64'h8000_0004, 3'd2, 8'h00, 64'd0, 64'h1111_2222_3333_4444, 64'h1111_2222, 0, 1, 0);
    i_valid = 0;
    // store and fetch contend: D first, then I
    i_valid = 1;
    i_addr = 64'h40;
    d_valid = 1;
    d_addr = 64'h10;
    d_size = 3'd3;
    d_strobe = 8'hFF;
    d_wdata = 64'hDEAD;
    txn(1, 64'h10, 3'd3, 8'hFF, 64'hDEAD, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
    chk("cnt_after_d", dut.starve_cnt, 1);
    d_valid = 0;
    txn(0, 64'h40, 3'd2, 8'h00, 64'd0, 64'hAAAA_BBBB_CCCC_DDDD, 64'hCCCC_DDDD, 0, 0, 0);
    chk("cnt_after_i", dut.starve_cnt, 0);
    i_valid = 0;
    // starvation: four D grants then I
    i_valid = 1;
    i_addr = 64'h100;
    d_valid = 1;
    d_addr = 64'h200;
    d_size = 3'd2;
    d_strobe = 8'h00;
    d_wdata = 64'd0;
    for (int k = 0; k < 4; k++) begin
      txn(1, 64'h200, 3'd2, 8'h00, 64'd0, 64'(k + 7), 64'(k + 7), 0, 0, 0);
      chk("starve_cnt", dut.starve_cnt, 64'(k + 1));
    end
    txn(0, 64'h100, 3'd2, 8'h00, 64'd0, 64'h5555_6666_7777_8888, 64'h7777_8888, 0, 0, 0);
    i_valid = 0;
    chk("starve_clr", dut.starve_cnt, 0);
    txn(1, 64'h200, 3'd2, 8'h00, 64'd0, 64'h99, 64'h99, 0, 0, 0);
    chk("cnt_no_i", dut.starve_cnt, 0);
    d_valid = 0;
    // back-pressure with a spurious response during ISSUE
    d_valid = 1;
    d_addr = 64'h300;
    d_size = 3'd3;
    d_strobe = 8'h0F;
    d_wdata = 64'h1234;
    txn(1, 64'h300, 3'd3, 8'h0F, 64'h1234, 64'hFEED, 64'hFEED, 5, 1, 0);
    d_valid = 0;
    // requester drops valid while waiting
    d_valid = 1;
    d_addr = 64'h308;
    d_strobe = 8'h00;
    d_wdata = 64'd0;
    txn(1, 64'h308, 3'd3, 8'h00, 64'd0, 64'hC0FFEE, 64'hC0FFEE, 0, 2, 1);
    @(negedge clk);
    chk("drop_idle", m_valid, 0);
    step;
    @(negedge clk);
    chk("drop_stay_idle", m_valid, 0);
    // reset while waiting abandons the transaction
    i_valid = 1;
    i_addr = 64'h500;
    d_valid = 1;
    d_addr = 64'h600;
    d_size = 3'd2;
    d_strobe = 8'h0F;
    d_wdata = 64'h5;
    step;
    m_ready = 1;
    step;
    m_ready = 0;
    chk("pre_rst_cnt", dut.starve_cnt, 1);
    reset = 1;
    i_valid = 0;
    d_valid = 0;
    step;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    chk("mid_rst_m_size", m_size, 0);
    chk("mid_rst_m_strobe", m_strobe, 0);
    chk("mid_rst_m_wdata", m_wdata, 0);
    chk("mid_rst_grant_d", grant_d, 0);
    chk("mid_rst_cnt", dut.starve_cnt, 0);
    step;
    m_resp_valid = 1;
    m_resp_data = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("stale_resp_ok", {i_data_ok, d_data_ok}, 0);
    step;
    m_resp_valid = 0;
    @(negedge clk);
    chk("post_rst_idle", m_valid, 0);
    step;
    step;
    chk("queue_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares the single memory port between the core's instruction-fetch requester (I) and data-access requester (D).
- Grants one outstanding transaction at a time and latches the winner's request so the memory side sees stable fields.
- Routes the response back to the winner as a one-cycle data_ok pulse.
- Sits between the core's ibus/dbus outputs and the memory/cache port; D has priority, and a starvation counter bounds how long I can be locked out.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive D grants tolerated while I is waiting; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- i_valid  in  1  fetch request pending
- i_addr  in  64  fetch address, 4-byte aligned
- i_data_ok  out  1  one-cycle pulse: fetch done
- i_data  out  32  instruction word; valid while i_data_ok=1
- d_valid  in  1  data request pending
- d_addr  in  64  data address
- d_size  in  3  log2 of access bytes
- d_strobe  in  8  byte-write mask; 0 = read
- d_wdata  in  64  store data
- d_data_ok  out  1  one-cycle pulse: data access done
- d_data  out  64  load data; valid while d_data_ok=1
- m_valid  out  1  request to memory
- m_addr  out  64  latched address
- m_size  out  3  latched size; I transactions drive 3'd2
- m_strobe  out  8  latched strobe; I transactions drive 0
- m_wdata  out  64  latched store data; I transactions drive 0
- m_ready  in  1  memory accepts request this cycle
- m_resp_valid  in  1  memory response this cycle
- m_resp_data  in  64  response data, 8-byte aligned doubleword
- grant_d  out  1  current/last owner is D (debug)

## Operation
State machine: IDLE, ISSUE, WAIT.

- IDLE
  - With neither request, stay in IDLE.
  - With only one request, grant it.
  - With both requests: grant I if starve_cnt == STARVE_LIMIT, else grant D.
  - On grant: latch the winner's addr/size/strobe/wdata into m_* registers, set grant_d, go to ISSUE.
- ISSUE
  - m_valid=1.
  - When m_ready=1, go to WAIT; the m_valid=0 transition takes effect on the next cycle.
  - Any m_resp_valid seen in ISSUE is ignored.
- WAIT
  - m_valid=0.
  - When m_resp_valid=1, pulse the owner's data_ok for that cycle only (combinational from m_resp_valid & state==WAIT) and go to IDLE.

Response data:
- i_data = i_addr_latched[2] ? m_resp_data[63:32] : m_resp_data[31:0].
- d_data = m_resp_data unmodified.
- Byte/half selection and sign extension are done by the core's memory stage.

Starvation counter starve_cnt, 4 bits, updated only on a grant in IDLE:
- D granted while i_valid=1: increment, saturating at STARVE_LIMIT.
- I granted, or i_valid=0 at the grant: clear to 0.

Requester rules:
- A requester must hold valid and all fields stable until its data_ok.
- If a requester deasserts valid mid-transaction, the transaction still completes and data_ok still pulses.
- The non-owner's data_ok stays 0 throughout.

Reset:
- A synchronous reset in any state returns to IDLE, abandons the outstanding transaction and clears starve_cnt.
- Memory is reset by the same reset.

## Timing
- Reset values: state IDLE, m_valid 0, m_addr/m_size/m_strobe/m_wdata 0, i_data_ok 0, d_data_ok 0, grant_d 0, starve_cnt 0.
- Minimum latency: request seen in IDLE at cycle 0 -> m_valid=1 at cycle 1. If m_ready=1 at cycle 1, the earliest data_ok is cycle 2, when m_resp_valid=1.
- Each transaction costs one IDLE arbitration cycle after data_ok.
  - At the data_ok edge the requester advances, so the next arbitration sees its new request.
  - Peak throughput: one transaction per 3 cycles.
- m_valid is held continuously through ISSUE until m_ready. Request fields never change while m_valid=1 or in WAIT.
- Arbitration is evaluated only in IDLE. A request arriving in ISSUE or WAIT waits for the next IDLE.

## Test plan
- Single fetch: i_valid=1, i_addr=0x8000_0004; m_ready at cycle 1, m_resp_valid at cycle 3 with data 0x1111_2222_3333_4444 -> m_valid high only at cycle 1, i_data_ok pulses at cycle 3, i_data=0x1111_2222, d_data_ok stays 0.
- Store then contention: D store (addr 0x10, strobe 0xFF, wdata 0xDEAD) and I both valid -> D granted first with m_strobe=0xFF, m_wdata=0xDEAD; I served next with m_strobe=0, m_size=2.
- Starvation: I held valid, D re-requests after every completion, STARVE_LIMIT=4 -> exactly 4 D grants, then an I grant, then starve_cnt=0.
- Memory back-pressure: m_ready low for 5 cycles in ISSUE -> m_valid and m_addr stay constant for all 5; an m_resp_valid injected in ISSUE is ignored, with no data_ok.
- Reset mid-WAIT: assert reset in WAIT -> next cycle state IDLE, all outputs at reset values, no data_ok when the stale m_resp_valid arrives later.
- Requester drop: D deasserts d_valid in WAIT -> d_data_ok still pulses on m_resp_valid, and the state returns to IDLE.
